// File: rtl/prm_edge_scan_seq.sv
// Edge-scan sequencer: sweeps 15-bit edge codes onto the obstacle checker
// bank, OR-reduces the per-obstacle masks into one collision bit per edge,
// packs the bits LSB-first into words and streams them out valid/ready.
module prm_edge_scan_seq #(
  parameter int OBS_N  = 8,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [14:0]       code_first_i,
  input  logic [14:0]       code_last_i,
  output logic [14:0]       chk_code_o,
  input  logic [OBS_N-1:0]  chk_mask_i,
  output logic              word_valid_o,
  input  logic              word_ready_i,
  output logic [WORD_W-1:0] word_data_o,
  output logic              word_last_o,
  output logic [15:0]       blocked_cnt_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int IW = $clog2(WORD_W);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

  state_t            state;
  logic [14:0]       code_last_q;
  logic [WORD_W-1:0] pack_q;
  logic [IW-1:0]     idx_q;
  // pack_full_q: pack_q holds a complete word that could not move to the
  // output register yet; pack_last_q marks it as the scan's final word.
  logic              pack_full_q;
  logic              pack_last_q;

  logic              coll;
  logic              out_free;
  logic              stall;
  logic              is_last;
  logic              word_end;
  logic [WORD_W-1:0] pack_nxt;

  // Collision bit, stall detect and next pack value for the current code.
  always_comb begin
    coll     = |chk_mask_i;
    out_free = !word_valid_o || word_ready_i;
    stall    = pack_full_q && !out_free;
    is_last  = (chk_code_o == code_last_q);
    word_end = (idx_q == IW'(WORD_W-1)) || is_last;
    // Bit 0 of a new word starts from a clean register so unused high bits stay 0.
    pack_nxt = ((idx_q == '0) ? '0 : pack_q) | (WORD_W'(coll) << idx_q);
  end

  // Scan FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      code_last_q   <= '0;
      pack_q        <= '0;
      idx_q         <= '0;
      pack_full_q   <= 1'b0;
      pack_last_q   <= 1'b0;
      chk_code_o    <= '0;
      word_valid_o  <= 1'b0;
      word_data_o   <= '0;
      word_last_o   <= 1'b0;
      blocked_cnt_o <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start_i) begin
            code_last_q   <= code_last_i;
            blocked_cnt_o <= '0;
            idx_q         <= '0;
            pack_full_q   <= 1'b0;
            if (code_last_i < code_first_i) begin
              err_o  <= 1'b1;
              done_o <= 1'b1;
              state  <= S_DONE;
            end else begin
              err_o      <= 1'b0;
              chk_code_o <= code_first_i;
              busy_o     <= 1'b1;
              state      <= S_SCAN;
            end
          end
        end

        S_SCAN: begin
          if (!stall) begin
            // A parked word moves out as soon as the output slot frees up.
            if (pack_full_q) begin
              word_data_o  <= pack_q;
              word_last_o  <= pack_last_q;
              word_valid_o <= 1'b1;
            end else if (word_valid_o && word_ready_i) begin
              word_valid_o <= 1'b0;
              word_last_o  <= 1'b0;
            end
            pack_q <= pack_nxt;
            if (word_end) begin
              if (!pack_full_q && out_free) begin
                word_data_o  <= pack_nxt;
                word_last_o  <= is_last;
                word_valid_o <= 1'b1;
                pack_full_q  <= 1'b0;
              end else begin
                pack_full_q <= 1'b1;
                pack_last_q <= is_last;
              end
            end else begin
              pack_full_q <= 1'b0;
            end
            if (coll) blocked_cnt_o <= blocked_cnt_o + 16'd1;
            idx_q <= idx_q + 1'b1;
            if (is_last) state <= S_DRAIN;
            else         chk_code_o <= chk_code_o + 15'd1;
          end
        end

        S_DRAIN: begin
          if (pack_full_q) begin
            if (out_free) begin
              word_data_o  <= pack_q;
              word_last_o  <= pack_last_q;
              word_valid_o <= 1'b1;
              pack_full_q  <= 1'b0;
            end
          end else if (word_valid_o && word_ready_i) begin
            word_valid_o <= 1'b0;
            word_last_o  <= 1'b0;
            if (word_last_o) begin
              busy_o <= 1'b0;
              done_o <= 1'b1;
              state  <= S_DONE;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
